// File: rtl/b13_rx.sv
// b13_rx: 8N1 serial receiver, MSB-first data, single-byte holding register
// with sticky framing and overrun flags.
// Optional build macro: B13_RX_MAJORITY_EN selects 3-sample majority voting
// for every bit decision; sample timing is identical in both builds.
module b13_rx #(
    parameter int unsigned BIT_PERIOD  = 106,
    parameter int unsigned HALF_PERIOD = BIT_PERIOD / 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_in,
    input  logic       rd_ack,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       dsr,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_BREAK
    } state_t;

    localparam logic [15:0] HALF_LAST = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] BIT_LAST  = 16'(BIT_PERIOD - 1);

    state_t      state;
    state_t      state_next;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic        sync_q;
    logic        rx;
    logic [1:0]  prime_q;
    logic        armed;
    logic        bit_val;
    logic        at_half;
    logic        at_bit;
    logic        shift_en;
    logic        deliver_set;
    logic        deliver_q;
    logic        frame_set;
    logic        ack_take;

    // Two-flop synchronizer for the asynchronous line; idles high out of reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= 1'b1;
            rx     <= 1'b1;
        end else begin
            sync_q <= serial_in;
            rx     <= sync_q;
        end
    end

    // The synchronizer's reset value is not a real line sample, so start
    // detection stays disarmed until a genuine idle-high has been seen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prime_q <= '0;
            armed   <= 1'b0;
        end else begin
            prime_q <= {prime_q[0], 1'b1};
            if (prime_q[1] && rx)
                armed <= 1'b1;
        end
    end

`ifdef B13_RX_MAJORITY_EN
    logic rx_d1;
    logic rx_d2;

    // Two-deep history of rx for the three-sample vote ending at the sample point
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx;
            rx_d2 <= rx_d1;
        end
    end

    assign bit_val = (rx & rx_d1) | (rx & rx_d2) | (rx_d1 & rx_d2);
`else
    assign bit_val = rx;
`endif

    // Next-state and per-cycle event decode
    always_comb begin
        state_next  = state;
        at_half     = (cnt == HALF_LAST);
        at_bit      = (cnt == BIT_LAST);
        shift_en    = 1'b0;
        deliver_set = 1'b0;
        frame_set   = 1'b0;
        case (state)
            R_IDLE: begin
                if (armed && !rx)
                    state_next = R_START;
            end
            R_START: begin
                if (at_half)
                    state_next = bit_val ? R_IDLE : R_DATA;
            end
            R_DATA: begin
                if (at_bit) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7)
                        state_next = R_STOP;
                end
            end
            R_STOP: begin
                if (at_bit) begin
                    if (bit_val) begin
                        deliver_set = 1'b1;
                        state_next  = R_IDLE;
                    end else begin
                        frame_set  = 1'b1;
                        state_next = R_BREAK;
                    end
                end
            end
            R_BREAK: begin
                if (rx)
                    state_next = R_IDLE;
            end
            default: state_next = R_IDLE;
        endcase
    end

    // State register, bit-period counter, bit index and data shift register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= R_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            deliver_q <= 1'b0;
        end else begin
            state     <= state_next;
            deliver_q <= deliver_set;
            if (state_next != state || shift_en)
                cnt <= '0;
            else if (state inside {R_START, R_DATA, R_STOP})
                cnt <= cnt + 16'd1;
            if (state != R_DATA)
                bit_idx <= '0;
            else if (shift_en)
                bit_idx <= bit_idx + 3'd1;
            if (shift_en)
                shift_reg <= {shift_reg[6:0], bit_val};
        end
    end

    assign ack_take = rd_ack & data_valid;

    // Holding register, consumer handshake and sticky error flags.
    // A delivery coinciding with an accepted rd_ack replaces the byte and
    // counts as a read of the old one, so errors clear rather than overrun.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            dsr         <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            dsr <= ~data_valid;
            if (deliver_q) begin
                if (data_valid && !rd_ack) begin
                    overrun_err <= 1'b1;
                end else begin
                    data_out   <= shift_reg;
                    data_valid <= 1'b1;
                    if (ack_take) begin
                        overrun_err <= 1'b0;
                        frame_err   <= 1'b0;
                    end
                end
            end else if (ack_take) begin
                data_valid  <= 1'b0;
                overrun_err <= 1'b0;
                frame_err   <= 1'b0;
            end
            if (frame_set)
                frame_err <= 1'b1;
        end
    end

    assign busy = (state != R_IDLE);

endmodule

// File: tb/tb_b13_rx.sv
// tb_b13_rx: directed-vector bench for b13_rx with a byte scoreboard.
// Expected bytes are queued before each frame; a negedge monitor pops and
// compares whenever a new byte appears in the holding register.
module tb_b13_rx;

    localparam int BP = 106;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       serial_in = 1'b1;
    logic       rd_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       dsr;
    logic       frame_err;
    logic       overrun_err;
    logic       busy;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic       prev_valid = 1'b0;
    logic [7:0] prev_out = '0;
    int         lat_n;
    logic       dsr_at_load;
    logic       dsr_after;
    int         n;

    b13_rx #(.BIT_PERIOD(BP)) dut (
        .clock      (clock),
        .reset      (reset),
        .serial_in  (serial_in),
        .rd_ack     (rd_ack),
        .data_out   (data_out),
        .data_valid (data_valid),
        .dsr        (dsr),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives start, 8 data bits MSB first and the stop bit; leaves the line at
    // the stop value. With glitch set, the slot each bit is sampled from is inverted.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic glitch);
        logic v;
        for (int w = 0; w < 10; w++) begin
            if (w == 0)      v = 1'b0;
            else if (w == 9) v = stop_bit;
            else             v = b[8 - w];
            for (int c = 0; c < BP; c++) begin
                serial_in = (glitch && c == 53) ? ~v : v;
                tick(1);
            end
        end
        serial_in = stop_bit;
    endtask

    task automatic ack_pulse();
        rd_ack = 1'b1;
        tick(1);
        rd_ack = 1'b0;
    endtask

    // Scoreboard monitor: a new byte is a rising data_valid or a changed data_out while valid
    always @(negedge clock) begin
        if (reset) begin
            if (data_valid && (!prev_valid || data_out != prev_out)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got %0h expected none", data_out);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (data_out !== e) begin
                        n_err++;
                        $display("FAIL sb_byte: got %0h expected %0h", data_out, e);
                    end
                end
            end
        end
        prev_valid = data_valid;
        prev_out   = data_out;
    end

    initial begin
        // Reset values
        tick(3);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_dsr", dsr, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_overrun_err", overrun_err, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b1;
        tick(1);
        chk("dsr_after_release", dsr, 1);
        tick(20);

        // 0xA5 with latency measurement from the falling start edge
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            begin
                lat_n = 0;
                while (!data_valid && lat_n < 1200) begin
                    tick(1);
                    lat_n++;
                end
                dsr_at_load = dsr;
                tick(1);
                dsr_after = dsr;
            end
        join
        serial_in = 1'b1;
        chk("a5_latency_window", (lat_n >= 1008 && lat_n <= 1012), 1);
        chk("a5_data_out", data_out, 8'hA5);
        chk("a5_dsr_at_load", dsr_at_load, 1);
        chk("a5_dsr_next", dsr_after, 0);
        ack_pulse();
        chk("a5_ack_valid", data_valid, 0);
        tick(20);

        // False start: 20 low cycles
        serial_in = 1'b0;
        tick(20);
        chk("fs_busy_high", busy, 1);
        serial_in = 1'b1;
        n = 20;
        while (busy && n < 200) begin
            tick(1);
            n++;
        end
        chk("fs_busy_return", (n >= 50 && n <= 62), 1);
        chk("fs_no_valid", data_valid, 0);
        tick(20);

        // Framing error: 0x3C with stop 0, line held low
        send_frame(8'h3C, 1'b0, 1'b0);
        tick(300);
        chk("fe_frame_err", frame_err, 1);
        chk("fe_no_valid", data_valid, 0);
        chk("fe_busy_break", busy, 1);
        ack_pulse();
        chk("fe_ack_ignored", frame_err, 1);
        serial_in = 1'b1;
        tick(5);
        chk("fe_busy_idle", busy, 0);
        tick(20);

        // Overrun: 0x11 then 0x22 without reading
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0);
        tick(20);
        send_frame(8'h22, 1'b1, 1'b0);
        tick(20);
        chk("ov_data_out", data_out, 8'h11);
        chk("ov_valid", data_valid, 1);
        chk("ov_overrun", overrun_err, 1);
        ack_pulse();
        chk("ov_ack_valid", data_valid, 0);
        chk("ov_ack_overrun", overrun_err, 0);
        chk("ov_ack_frame", frame_err, 0);
        tick(1);
        chk("ov_dsr", dsr, 1);
        tick(20);

        // rd_ack in the exact delivery cycle of 0x77 over held 0x66
        exp_q.push_back(8'h66);
        send_frame(8'h66, 1'b1, 1'b0);
        tick(20);
        exp_q.push_back(8'h77);
        fork
            send_frame(8'h77, 1'b1, 1'b0);
            begin
                tick(1010);
                rd_ack = 1'b1;
                tick(1);
                rd_ack = 1'b0;
            end
        join
        tick(5);
        chk("same_data_out", data_out, 8'h77);
        chk("same_valid", data_valid, 1);
        chk("same_overrun", overrun_err, 0);
        ack_pulse();
        tick(20);

        // Reset during bit 4, line left low
        serial_in = 1'b0;
        tick(BP * 5 + 20);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_dsr", dsr, 0);
        tick(3);
        reset = 1'b1;
        tick(1500);
        chk("mid_rst_idle", busy, 0);
        chk("mid_rst_no_valid", data_valid, 0);
        chk("mid_rst_no_ferr", frame_err, 0);
        serial_in = 1'b1;
        tick(20);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0);
        tick(20);
        chk("clean_5a", data_out, 8'h5A);
        ack_pulse();
        tick(20);

`ifdef B13_RX_MAJORITY_EN
        // One-cycle glitch at every sample point is voted out
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b1);
        tick(20);
        chk("glitch_5a", data_out, 8'h5A);
        chk("glitch_no_ferr", frame_err, 0);
        ack_pulse();
        tick(20);
`endif

        tick(50);
        chk("sb_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
